// File: rtl/blink_period_meter.sv
// blink_period_meter: measures the edge-to-edge half-period of an asynchronous blink input
//   Ports: clk (40 MHz), rst (async, active-high), sig_in (async blink input)
//          half_period  [CNT_W] last measured edge-to-edge distance in clk cycles
//          period_valid         one-cycle pulse when half_period updates
//          locked               LOCK_CNT consecutive intervals within TOL of their predecessor
//          stuck / stuck_level  no edge for TIMEOUT cycles / synchronized level at that moment
//   Optional glitch filter: define BLINK_METER_GLITCH_FILTER_EN (uses FILT_LEN).
module blink_period_meter #(
    parameter int CNT_W    = 32,
    parameter int TIMEOUT  = 40_000_000,
    parameter int LOCK_CNT = 4,
    parameter int TOL      = 2,
    parameter int FILT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             locked,
    output logic             stuck,
    output logic             stuck_level
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
    localparam logic [MW-1:0] LCK = MW'(LOCK_CNT);
    typedef enum logic [1:0] {IDLE, ARMED, MEAS} state_t;
    state_t state, state_n;
    logic s1, s2, sig_edge, timeout;
    logic [CNT_W-1:0] cnt, meas, diff, prev, prev_n, hp_n;
    logic [MW-1:0] match_cnt, match_n;
    logic pv_n, lk_n, st_n, sl_n;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
        end

`ifdef BLINK_METER_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILT_LEN + 1);
    logic flt;
    logic [FW-1:0] fcnt;
    // flt is the accepted level; s2 must disagree with it for FILT_LEN cycles in a row
    assign sig_edge = (s2 != flt) && (fcnt == FW'(FILT_LEN - 1));
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            flt  <= 1'b0;
            fcnt <= '0;
        end else begin
            fcnt <= (s2 == flt || sig_edge) ? '0 : fcnt + 1'b1;
            flt  <= sig_edge ? s2 : flt;
        end
`else
    logic s3;
    always_ff @(posedge clk or posedge rst)
        if (rst) s3 <= 1'b0;
        else     s3 <= s2;
    assign sig_edge = s2 ^ s3;
`endif

    // meas is the exact distance to the previous edge; an edge landing on the timeout cycle wins
    assign meas    = cnt + 1'b1;
    assign timeout = !sig_edge && (meas == TMO);
    assign diff    = (meas >= prev) ? meas - prev : prev - meas;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;

    always_comb begin
        state_n = state;
        prev_n  = prev;
        match_n = match_cnt;
        hp_n    = half_period;
        pv_n    = 1'b0;
        lk_n    = locked;
        st_n    = stuck;
        sl_n    = stuck_level;
        if (sig_edge && state == IDLE) begin
            state_n = ARMED;
            st_n    = 1'b0;
            match_n = '0;
        end else if (sig_edge) begin
            // every edge after arming reports; only MEAS already holds a prev to compare with
            state_n = MEAS;
            prev_n  = meas;
            hp_n    = meas;
            pv_n    = 1'b1;
            if (state == MEAS && diff <= CNT_W'(TOL)) begin
                match_n = (match_cnt == LCK) ? match_cnt : match_cnt + 1'b1;
                lk_n    = locked | (match_n == LCK);
            end else if (state == MEAS) begin
                match_n = '0;
                lk_n    = 1'b0;
            end
        end else if (timeout) begin
            state_n = IDLE;
            st_n    = 1'b1;
            sl_n    = s2;
            lk_n    = 1'b0;
            match_n = '0;
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt          <= '0;
            prev         <= '0;
            match_cnt    <= '0;
            half_period  <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            stuck        <= 1'b0;
            stuck_level  <= 1'b0;
        end else begin
            cnt          <= sig_edge ? '0 : (meas == TMO ? cnt : meas);
            prev         <= prev_n;
            match_cnt    <= match_n;
            half_period  <= hp_n;
            period_valid <= pv_n;
            locked       <= lk_n;
            stuck        <= st_n;
            stuck_level  <= sl_n;
        end
endmodule
